// File: rtl/gf64_reduce_pipe.sv
// Two-stage GF(2^64) reduction of a 127-bit carry-less product modulo x^64 + POLY_LOW(x).
// Stage 1 folds bits 126:64 back into a 71-bit value; stage 2 folds the remaining 7 overflow bits.
module gf64_reduce_pipe #(
    parameter logic [63:0] POLY_LOW = 64'h1B,
    parameter int          TAG_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [126:0]       in_prod,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // Handshake: a beat moves across a port on a rising edge where valid and ready are both
    // high; a producer holds valid and payload stable until that edge; ready never depends on
    // valid of the same port. Each stage advances when it is empty or its successor advances.

    logic               s1_valid;
    logic [70:0]        s1_t;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_valid;
    logic [63:0]        s2_d;
    logic [TAG_W-1:0]   s2_tag;
    logic               adv1;
    logic               adv2;
    logic [70:0]        fold1;
    logic [63:0]        fold2;

    // POLY_LOW has degree <= 8, so only its low nine coefficients take part.
    function automatic logic [70:0] clmul_hi(input logic [62:0] h);
        logic [70:0] acc;
        acc = '0;
        for (int j = 0; j < 9; j++) begin
            if (POLY_LOW[j]) acc = acc ^ ({8'b0, h} << j);
        end
        return acc;
    endfunction

    function automatic logic [63:0] clmul_ov(input logic [6:0] o);
        logic [63:0] acc;
        acc = '0;
        for (int j = 0; j < 9; j++) begin
            if (POLY_LOW[j]) acc = acc ^ ({57'b0, o} << j);
        end
        return acc;
    endfunction

    assign fold1 = {7'b0, in_prod[63:0]} ^ clmul_hi(in_prod[126:64]);
    assign fold2 = s1_t[63:0] ^ clmul_ov(s1_t[70:64]);

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_t     <= '0;
            s1_tag   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid && in_ready;
            s1_t     <= fold1;
            s1_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_d     <= '0;
            s2_tag   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            s2_d     <= fold2;
            s2_tag   <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_d;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_gf64_reduce_pipe.sv
// Directed and random checks of gf64_reduce_pipe against a bit-serial polynomial-division model.
module tb_gf64_reduce_pipe;

    localparam int          TAG_W = 4;
    localparam int          W     = 64 + TAG_W;
    localparam logic [63:0] POLY  = 64'h1B;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [126:0]       in_prod;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;
    logic [TAG_W-1:0]   out_tag;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errs   = 0;
    int n_drain  = 0;

    gf64_reduce_pipe #(.POLY_LOW(POLY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Long division by x^64 + POLY, highest degree first.
    function automatic logic [63:0] ref_reduce(input logic [126:0] p);
        logic [127:0] v;
        logic [127:0] pm;
        v  = {1'b0, p};
        pm = {63'b0, 1'b1, POLY};
        for (int i = 126; i >= 64; i--) begin
            if (v[i]) v = v ^ (pm << (i - 64));
        end
        return v[63:0];
    endfunction

    function automatic logic [126:0] rnd_prod();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[126:0];
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // driver: one clock cycle, entered and left just after a falling edge
    task automatic step(input logic iv, input logic [126:0] prod, input logic [TAG_W-1:0] tg,
                        input logic ordy, input logic has_exp, input logic [63:0] exp_d,
                        output logic accepted);
        logic [W-1:0] e;
        in_valid  = iv;
        in_prod   = prod;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        accepted = iv && in_ready;
        if (out_valid && out_ready) begin
            n_drain++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 128'(out_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 128'(out_data), 128'(e[W-1:TAG_W]));
                check("out_tag", 128'(out_tag), 128'(e[TAG_W-1:0]));
            end
        end
        if (accepted) exp_q.push_back({has_exp ? exp_d : ref_reduce(prod), tg});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [126:0] prod, input logic [TAG_W-1:0] tg,
                        input logic has_exp, input logic [63:0] exp_d);
        logic acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, prod, tg, 1'b1, has_exp, exp_d, acc);
            tries++;
        end
        check("send_accepted", 128'(acc), 128'(1));
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, '0, '0, ordy, 1'b0, '0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic         acc;
        logic [126:0] p;
        logic [TAG_W-1:0] t;
        logic [63:0]  held_d;
        logic [TAG_W-1:0] held_t;
        int           sent;
        int           d0;

        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // zero product, latency
        step(1'b1, '0, 4'd3, 1'b1, 1'b1, 64'h0, acc);
        check("t1_accept", 128'(acc), 128'(1));
        check("t1_valid_k1", 128'(out_valid), 128'(0));
        idle(1'b0);
        check("t1_valid_k2", 128'(out_valid), 128'(1));
        check("t1_data", 128'(out_data), 128'(0));
        check("t1_tag", 128'(out_tag), 128'(3));
        drain();

        // single folds and pass-through
        send(127'h1 << 64, 4'd5, 1'b1, 64'h1B);
        send(127'h1234, 4'd6, 1'b1, 64'h1234);
        send(127'h1 << 126, 4'd7, 1'b1, 64'hC000_0000_0000_005A);
        drain();

        // 10 back-to-back random products
        d0 = n_drain;
        for (int i = 0; i < 10; i++) send(rnd_prod(), 4'(i), 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        check("t4_consecutive", 128'(n_drain - d0), 128'(10));
        drain();

        // stall mid-burst
        p = rnd_prod(); t = 4'd0; sent = 0; held_d = '0; held_t = '0;
        for (int c = 0; c < 24; c++) begin
            if (c == 6) begin
                held_d = out_data;
                held_t = out_tag;
            end
            step(sent < 15, p, t, !(c >= 6 && c < 11), 1'b0, '0, acc);
            if (acc) begin
                p = rnd_prod();
                t = t + 4'd1;
                sent++;
            end
            if (c >= 6 && c < 11) begin
                check("t5_in_ready", 128'(in_ready), 128'(0));
                check("t5_out_valid", 128'(out_valid), 128'(1));
                check("t5_hold_data", 128'(out_data), 128'(held_d));
                check("t5_hold_tag", 128'(out_tag), 128'(held_t));
            end
        end
        check("t5_sent", 128'(sent), 128'(15));
        drain();

        // reset with both stages full
        step(1'b1, rnd_prod(), 4'd9, 1'b0, 1'b0, '0, acc);
        step(1'b1, rnd_prod(), 4'd10, 1'b0, 1'b0, '0, acc);
        check("t6_full", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(out_valid), 128'(0));
        check("t6_rst_data", 128'(out_data), 128'(0));
        check("t6_rst_tag", 128'(out_tag), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        p = rnd_prod();
        step(1'b1, p, 4'd12, 1'b1, 1'b0, '0, acc);
        check("t6_accept", 128'(acc), 128'(1));
        check("t6_valid_k1", 128'(out_valid), 128'(0));
        idle(1'b0);
        check("t6_valid_k2", 128'(out_valid), 128'(1));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
